// File: rtl/mnist_out_pkg.sv
// Shared constants, FSM state type and score-slice helper for the MNIST
// ensemble output stage (ens_vote_argmax and argmax_scan_unit).
package mnist_out_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 2;
  localparam int NUM_ENS     = 4;
  // Derived widths: ACC_W covers NUM_ENS*(2^SCORE_W-1) so sums never wrap.
  localparam int ACC_W       = SCORE_W + $clog2(NUM_ENS);
  localparam int CLS_W       = $clog2(NUM_CLASSES);
  // Beat counter keeps at least one bit so NUM_ENS=1 still elaborates.
  localparam int BEAT_W      = (NUM_ENS > 1) ? $clog2(NUM_ENS) : 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [SCORE_W-1:0] score_slice(
    input logic [NUM_CLASSES*SCORE_W-1:0] vec,
    input int                             c
  );
    return vec[c*SCORE_W +: SCORE_W];
  endfunction

endpackage

// File: rtl/argmax_scan_unit.sv
// Sequential argmax: walks one class per enabled cycle, keeping the running
// best score and its index. Strict compare, so ties keep the lowest index.
// Ports:
//   clk, rst      clock / async active-high reset
//   en_i          step the scan this cycle (acc_i is the score at idx_o)
//   clr_i         restart the scan at class 0
//   acc_i         accumulated score of class idx_o
//   idx_o         class currently being examined
//   done_o        last class is being examined this cycle
//   win_idx_o     winner including this cycle's compare (valid with done_o)
//   win_score_o   score of that winner
module argmax_scan_unit
  import mnist_out_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [CLS_W-1:0] idx_o,
  output logic             done_o,
  output logic [CLS_W-1:0] win_idx_o,
  output logic [ACC_W-1:0] win_score_o
);

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

  logic [CLS_W-1:0] idx_q, idx_d;
  logic [CLS_W-1:0] best_idx_q, best_idx_d;
  logic [ACC_W-1:0] best_q, best_d;
  logic             take;

  always_comb begin
    // Class 0 seeds the search unconditionally; later classes must beat it.
    take       = (idx_q == '0) || (acc_i > best_q);
    best_d     = take ? acc_i : best_q;
    best_idx_d = take ? idx_q : best_idx_q;
    done_o     = en_i && (idx_q == LAST_IDX);
    idx_d      = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = done_o ? '0 : idx_q + CLS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      idx_q <= idx_d;
      if (en_i) begin
        best_q     <= best_d;
        best_idx_q <= best_idx_d;
      end
    end
  end

  assign idx_o       = idx_q;
  assign win_idx_o   = best_idx_d;
  assign win_score_o = best_d;

endmodule

// File: rtl/ens_vote_argmax.sv
// Ensemble vote output stage: sums NUM_ENS class-score vectors per class,
// scans for the highest total and presents the winning digit on a
// valid/ready handshake.
// Ports:
//   clk, rst              clock / async active-high reset
//   in_valid, in_ready    score-vector handshake (in_ready only in ACCUM)
//   in_scores             class c at [c*SCORE_W +: SCORE_W], unsigned
//   out_valid, out_ready  result handshake
//   out_class, out_score  winning class and its accumulated score
//
// state | meaning
// ACCUM | accepting score vectors, beat counts members received
// SCAN  | argmax walks one class per cycle over the sums
// HOLD  | result presented, waiting for out_ready
module ens_vote_argmax
  import mnist_out_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CLASSES*SCORE_W-1:0] in_scores,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLS_W-1:0]               out_class,
  output logic [ACC_W-1:0]               out_score
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_ENS - 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ACC_W-1:0]  acc_q [NUM_CLASSES];
  logic [ACC_W-1:0]  acc_d [NUM_CLASSES];
  logic              out_valid_q, out_valid_d;
  logic [CLS_W-1:0]  out_class_q, out_class_d;
  logic [ACC_W-1:0]  out_score_q, out_score_d;

  logic              scan_en, scan_clr, scan_done;
  logic [CLS_W-1:0]  scan_idx, win_idx;
  logic [ACC_W-1:0]  win_score;

  assign in_ready = (state_q == ACCUM);

  argmax_scan_unit u_scan (
    .clk         (clk),
    .rst         (rst),
    .en_i        (scan_en),
    .clr_i       (scan_clr),
    .acc_i       (acc_q[scan_idx]),
    .idx_o       (scan_idx),
    .done_o      (scan_done),
    .win_idx_o   (win_idx),
    .win_score_o (win_score)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    scan_en     = 1'b0;
    scan_clr    = 1'b0;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          // First beat overwrites, so the previous group's sums never leak in.
          for (int c = 0; c < NUM_CLASSES; c++) begin
            if (beat_q == '0) begin
              acc_d[c] = ACC_W'(score_slice(in_scores, c));
            end else begin
              acc_d[c] = acc_q[c] + ACC_W'(score_slice(in_scores, c));
            end
          end
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            scan_clr = 1'b1;
            state_d  = SCAN;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (scan_done) begin
          out_valid_d = 1'b1;
          out_class_d = win_idx;
          out_score_d = win_score;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;

endmodule

// File: tb/tb_ens_vote_argmax.sv
module tb_ens_vote_argmax;
  import mnist_out_pkg::*;

  localparam int VW = NUM_CLASSES * SCORE_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_scores;
  logic          out_valid;
  logic          out_ready;
  logic [CLS_W-1:0] out_class;
  logic [ACC_W-1:0] out_score;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc_cyc = 0;
  logic [VW-1:0] grp [NUM_ENS];

  ens_vote_argmax dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_scores (in_scores),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk(input int c, input int s);
    logic [VW-1:0] r;
    r = VW'(s) << (SCORE_W * c);
    return r;
  endfunction

  // Reference: plain per-class sums over the group, first maximum wins.
  task automatic model(output int cls, output int sc);
    int sums [NUM_CLASSES];
    logic [VW-1:0] v;
    for (int c = 0; c < NUM_CLASSES; c++) sums[c] = 0;
    for (int b = 0; b < NUM_ENS; b++) begin
      v = grp[b];
      for (int c = 0; c < NUM_CLASSES; c++)
        sums[c] += int'((v >> (SCORE_W * c)) & VW'(3));
    end
    cls = 0;
    sc  = sums[0];
    for (int c = 1; c < NUM_CLASSES; c++)
      if (sums[c] > sc) begin cls = c; sc = sums[c]; end
  endtask

  // Called at a negedge; returns at the negedge right after the transfer.
  task automatic send_beat(input logic [VW-1:0] v);
    int n = 0;
    in_valid  = 1'b1;
    in_scores = v;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("beat_timeout", 0, 1);
    @(negedge clk);
    in_valid     = 1'b0;
    in_scores    = VW'($urandom());
    last_acc_cyc = cyc;
  endtask

  task automatic send_group(input int max_gap);
    for (int b = 0; b < NUM_ENS; b++) begin
      send_beat(grp[b]);
      if (max_gap > 0 && b < NUM_ENS - 1) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  // Waits for the result, checks latency and value, holds it for `hold`
  // cycles with junk offered on the input, then accepts it.
  task automatic get_result(input string tag, input int hold);
    int n = 0;
    int ecls, esc;
    model(ecls, esc);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_lat"}, cyc - last_acc_cyc, NUM_CLASSES);
    check({tag, "_cls"}, out_class, ecls);
    check({tag, "_score"}, out_score, esc);
    check({tag, "_inrdy_hold"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_scores = VW'($urandom());
      @(negedge clk);
      check({tag, "_bp_valid"}, out_valid, 1);
      check({tag, "_bp_cls"}, out_class, ecls);
      check({tag, "_bp_score"}, out_score, esc);
      check({tag, "_bp_inrdy"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_inrdy_back"}, in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_scores = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_class", out_class, 0);
    check("rst_out_score", out_score, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single dominant class; out_ready held high throughout.
    for (int b = 0; b < NUM_ENS; b++) grp[b] = mk(7, 3);
    out_ready = 1'b1;
    send_group(0);
    get_result("t1", 0);

    // Tie between classes 2 and 8 at 5; class 5 at 4.
    grp[0] = mk(2, 2) | mk(8, 3) | mk(5, 1);
    grp[1] = mk(2, 1) | mk(8, 2) | mk(5, 1);
    grp[2] = mk(2, 1) | mk(5, 1);
    grp[3] = mk(2, 1) | mk(5, 1);
    send_group(0);
    get_result("t2_tie", 0);

    // Gapped input: valid pattern 1-0-0-1-1-0-1.
    grp[0] = mk(0, 1) | mk(4, 1);
    grp[1] = mk(0, 2) | mk(4, 1);
    grp[2] = mk(0, 3) | mk(4, 1);
    grp[3] = mk(0, 0) | mk(4, 1);
    send_beat(grp[0]);
    repeat (2) @(negedge clk);
    send_beat(grp[1]);
    send_beat(grp[2]);
    @(negedge clk);
    send_beat(grp[3]);
    get_result("t3_gap", 0);

    // Backpressure for 20 cycles with junk offered on the input.
    for (int b = 0; b < NUM_ENS; b++) grp[b] = mk(6, b) | mk(1, 1);
    send_group(0);
    get_result("t4_bp", 20);

    // Back-to-back groups: winner 3 then 9, no carry-over.
    for (int b = 0; b < NUM_ENS; b++) grp[b] = mk(3, 3) | mk(9, 1);
    send_group(0);
    get_result("t5a", 0);
    for (int b = 0; b < NUM_ENS; b++) grp[b] = mk(9, 1) | mk(3, 0);
    send_group(0);
    get_result("t5b", 0);

    // Async reset in mid-SCAN (idx=4), then a fresh group.
    for (int b = 0; b < NUM_ENS; b++) grp[b] = mk(5, 2);
    send_group(0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_inrdy", in_ready, 1);
    check("t6_rst_cls", out_class, 0);
    check("t6_rst_score", out_score, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int b = 0; b < NUM_ENS; b++) grp[b] = mk(4, 1) | mk(1, b % 2);
    send_group(0);
    get_result("t6_fresh", 0);

    // Randomized groups with random gaps and backpressure.
    for (int g = 0; g < 16; g++) begin
      for (int b = 0; b < NUM_ENS; b++) grp[b] = VW'($urandom());
      send_group(2);
      get_result($sformatf("rnd%0d", g), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
